// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX->MEM pipeline stage.
// The payload struct carries GPR write-back, HI/LO write and load/store
// fields as one unit so the skid buffer can treat it as an opaque vector.
package ex_mem_pkg;

  localparam int PKG_DATA_W     = 32;
  localparam int PKG_REG_ADDR_W = 5;
  localparam int PKG_ALUOP_W    = 8;

  localparam logic [PKG_REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic [PKG_DATA_W-1:0]     ZERO_WORD    = '0;

  // Skid buffer occupancy, also the buffer's only state.
  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_e;

  // Full payload, HI/LO included.
  typedef struct packed {
    logic [PKG_REG_ADDR_W-1:0] waddr;
    logic                      wen;
    logic [PKG_DATA_W-1:0]     wdata;
    logic                      hilo_wen;
    logic [PKG_DATA_W-1:0]     hi;
    logic [PKG_DATA_W-1:0]     lo;
    logic [PKG_ALUOP_W-1:0]    aluop;
    logic [PKG_DATA_W-1:0]     mem_addr;
    logic [PKG_DATA_W-1:0]     reg2;
  } ex_mem_payload_t;

  // Stored subset when HI/LO storage is compiled out.
  typedef struct packed {
    logic [PKG_REG_ADDR_W-1:0] waddr;
    logic                      wen;
    logic [PKG_DATA_W-1:0]     wdata;
    logic [PKG_ALUOP_W-1:0]    aluop;
    logic [PKG_DATA_W-1:0]     mem_addr;
    logic [PKG_DATA_W-1:0]     reg2;
  } ex_mem_core_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// ex_mem_skid_buf: generic 2-entry skid buffer over an opaque payload.
// Head register drives the output; the skid register absorbs the one
// extra entry accepted in the cycle after downstream stalls.
// Occupancy is exposed on o_occ so users can decode valid/ready.
module ex_mem_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic         i_ready,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output occ_e         o_occ
);

  occ_e         r_occ;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_in;
  logic         w_out;

  // Upstream ready depends only on registered occupancy, never on i_ready.
  assign w_in  = i_valid & (r_occ != OCC2) & i_rst_n;
  assign w_out = i_ready & (r_occ != OCC0);

  // Occupancy FSM with head/skid payload registers; flush beats in/out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= OCC0;
      r_head <= '0;
      r_skid <= '0;
    end else if (i_flush) begin
      r_occ <= OCC0;
    end else begin
      case (r_occ)
        OCC0: begin
          if (w_in) begin
            r_head <= i_data;
            r_occ  <= OCC1;
          end
        end
        OCC1: begin
          if (w_in && w_out) begin
            r_head <= i_data;
          end else if (w_out) begin
            r_occ <= OCC0;
          end else if (w_in) begin
            r_skid <= i_data;
            r_occ  <= OCC2;
          end
        end
        OCC2: begin
          if (w_out) begin
            r_head <= r_skid;
            r_occ  <= OCC1;
          end
        end
        default: r_occ <= OCC0;
      endcase
    end
  end

  assign o_data = r_head;
  assign o_occ  = r_occ;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage with a 2-entry skid buffer.
// Optional feature macro: EX_MEM_PIPE_HILO_EN (HI/LO fields stored and
// passed through; when undefined HI/LO outputs are tied to zero).
//
// Handshake: an entry moves in when ex_valid & ex_ready and out when
// mem_valid & mem_ready, both sampled on the rising clk edge; ex_ready is
// decoded from registered occupancy only, so no path exists from mem_ready.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = PKG_DATA_W,
  parameter int REG_ADDR_W = PKG_REG_ADDR_W,
  parameter int ALUOP_W    = PKG_ALUOP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  ex_wen,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_hilo_wen,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_hilo_wen,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic                  fwd_wen,
  output logic [REG_ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]     fwd_wdata
);

  ex_mem_payload_t w_out_pl;
  occ_e            w_occ;

`ifdef EX_MEM_PIPE_HILO_EN
  ex_mem_payload_t w_in_pl;
  ex_mem_payload_t w_head_pl;

  // Pack inputs; a HI/LO entry never also writes a GPR.
  always_comb begin
    w_in_pl          = '0;
    w_in_pl.waddr    = ex_waddr;
    w_in_pl.wen      = ex_wen & ~ex_hilo_wen;
    w_in_pl.wdata    = ex_wdata;
    w_in_pl.hilo_wen = ex_hilo_wen;
    w_in_pl.hi       = ex_hi;
    w_in_pl.lo       = ex_lo;
    w_in_pl.aluop    = ex_aluop;
    w_in_pl.mem_addr = ex_mem_addr;
    w_in_pl.reg2     = ex_reg2;
  end

  ex_mem_skid_buf #(.W($bits(ex_mem_payload_t))) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (flush),
    .i_valid (ex_valid),
    .i_ready (mem_ready),
    .i_data  (w_in_pl),
    .o_data  (w_head_pl),
    .o_occ   (w_occ)
  );

  assign w_out_pl = w_head_pl;
`else
  ex_mem_core_t w_in_core;
  ex_mem_core_t w_head_core;
  logic         w_unused_hilo;

  // HI/LO inputs have no storage in this build.
  assign w_unused_hilo = ^{ex_hilo_wen, ex_hi, ex_lo};

  // Pack the stored subset; GPR enable passes straight through.
  always_comb begin
    w_in_core          = '0;
    w_in_core.waddr    = ex_waddr;
    w_in_core.wen      = ex_wen;
    w_in_core.wdata    = ex_wdata;
    w_in_core.aluop    = ex_aluop;
    w_in_core.mem_addr = ex_mem_addr;
    w_in_core.reg2     = ex_reg2;
  end

  ex_mem_skid_buf #(.W($bits(ex_mem_core_t))) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (flush),
    .i_valid (ex_valid),
    .i_ready (mem_ready),
    .i_data  (w_in_core),
    .o_data  (w_head_core),
    .o_occ   (w_occ)
  );

  // Widen the stored subset back to the full payload with HI/LO at zero.
  always_comb begin
    w_out_pl          = '0;
    w_out_pl.waddr    = w_head_core.waddr;
    w_out_pl.wen      = w_head_core.wen;
    w_out_pl.wdata    = w_head_core.wdata;
    w_out_pl.hilo_wen = 1'b0;
    w_out_pl.hi       = ZERO_WORD;
    w_out_pl.lo       = ZERO_WORD;
    w_out_pl.aluop    = w_head_core.aluop;
    w_out_pl.mem_addr = w_head_core.mem_addr;
    w_out_pl.reg2     = w_head_core.reg2;
  end
`endif

  assign ex_ready  = (w_occ != OCC2) & rst;
  assign mem_valid = (w_occ != OCC0);

  // Enables are qualified by valid so a bubble or flushed slot never writes.
  assign mem_waddr    = w_out_pl.waddr;
  assign mem_wen      = w_out_pl.wen & mem_valid;
  assign mem_wdata    = w_out_pl.wdata;
  assign mem_hilo_wen = w_out_pl.hilo_wen & mem_valid;
  assign mem_hi       = w_out_pl.hi;
  assign mem_lo       = w_out_pl.lo;
  assign mem_aluop    = w_out_pl.aluop;
  assign mem_mem_addr = w_out_pl.mem_addr;
  assign mem_reg2     = w_out_pl.reg2;

  assign fwd_wen   = mem_wen;
  assign fwd_waddr = mem_waddr;
  assign fwd_wdata = mem_wdata;

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer, replacing the fixed-width stall-pair register between execute and memory. It carries the GPR write-back, HI/LO write and load/store fields as one payload. It supports back-pressure, flush and bubble insertion without losing or duplicating an instruction. A HI/LO write can no longer bypass a stall. The block sits between the EX unit and the MEM unit; its forwarding outputs feed the ID-stage hazard/bypass logic.

## Interface
- DATA_W, 32, GPR/HI/LO/address data width
- REG_ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all held entries (exception/branch squash)
- ex_valid  in  1  EX presents a valid instruction
- ex_ready  out  1  stage can accept this cycle
- ex_waddr / ex_wen / ex_wdata  in  REG_ADDR_W / 1 / DATA_W  GPR write-back
- ex_hilo_wen / ex_hi / ex_lo  in  1 / DATA_W / DATA_W  HI/LO write
- ex_aluop / ex_mem_addr / ex_reg2  in  ALUOP_W / DATA_W / DATA_W  load/store op, address, store data
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes the entry (MEM not stalled)
- mem_waddr, mem_wen, mem_wdata, mem_hilo_wen, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  as inputs  payload of head entry
- fwd_wen / fwd_waddr / fwd_wdata  out  1 / REG_ADDR_W / DATA_W  head-entry GPR write for bypass

## Operation
- Storage: head register (drives outputs) plus one skid register; occupancy counter `occ` in {0,1,2}.
- Transfer in: `ex_valid & ex_ready`. Transfer out: `mem_valid & mem_ready`.
- `ex_ready = (occ != 2) & rst`, decoded from registered `occ`. There is no combinational path from `mem_ready`.
- occ0: in → head, occ1.
- occ1, out & in: head ← new entry, occ1. Out only: occ0. In only: skid ← new entry, occ2.
- occ2: no in. Out: head ← skid, occ1.
- `mem_valid = (occ != 0)`.
- `mem_wen`, `mem_hilo_wen` and `fwd_wen` are ANDed with `mem_valid`, so a bubble never writes.
- The HI/LO entry carries `mem_wen` = 0 whatever the value of `ex_wen`. GPR and HI/LO writes are mutually exclusive per entry.
- flush: next state is occ0 and all write enables clear. Flush wins over a simultaneous in or out. An input presented in the flush cycle is dropped.
- Payload data fields of invalid entries hold their previous value. Only the enables are required to be zero.

## Timing
- Latency: 1 cycle from in to `mem_valid`, with the pipe empty or with occ1 and `mem_ready`=1.
- Throughput: 1 entry/cycle while `mem_ready` is held high.
- After `mem_ready` drops, at most one further entry is accepted (into skid). `ex_ready` falls on the following cycle.
- Entries leave strictly in order. No entry is duplicated or lost except by flush.
- Reset: async assert clears `occ`, all enables and all payload to zero. Outputs are zero while `rst`=0. `ex_ready`=1 from the first clock edge after release.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Configuration
- `EX_MEM_PIPE_HILO_EN` defined: HI/LO fields are stored and passed through as above.
- Not defined: HI/LO storage is removed. `mem_hilo_wen`, `mem_hi` and `mem_lo` are tied to 0. `ex_hilo_wen`, `ex_hi` and `ex_lo` are ignored, and `mem_wen` follows `ex_wen` unconditionally.

## Structure
- Shared package `ex_mem_pkg`: payload struct `ex_mem_payload_t` (all fields above, widths from package constants), `NOP_REG_ADDR`, `ZERO_WORD`.
- Sub-module `ex_mem_skid_buf`: generic 2-entry skid buffer over an opaque payload vector, with flush. `ex_mem_pipe` packs and unpacks the struct and applies the enable qualification.

## Test plan
- Reset, then 3 back-to-back ALU ops (wdata 0x11, 0x22, 0x33 to r1, r2, r3) with `mem_ready`=1 → each appears on `mem_*` one cycle later, in order, with `mem_wen`=1.
- `mem_ready`=0 for 3 cycles during a stream → 2 entries held, `ex_ready`=0 from the second stall cycle. `mem_ready`=1 then drains both in order; none is lost or duplicated.
- MULT result with `ex_hilo_wen`=1, hi=0xDEAD, lo=0xBEEF, issued during a stall → waits for `mem_ready`, then `mem_hilo_wen`=1, hi=0xDEAD, lo=0xBEEF, `mem_wen`=0.
- `flush` at occ2, simultaneous with `ex_valid` → next cycle `mem_valid`=0 and all enables 0, and the flushed-cycle input never appears.
- Async reset asserted between clock edges while occ1 → outputs zero before the next edge. After release, `ex_ready`=1.
- Build without `EX_MEM_PIPE_HILO_EN`, `ex_hilo_wen`=1 with `ex_wen`=1 to r4 → `mem_hilo_wen`=0 and `mem_wen`=1 to r4.
